alu_issue_ctrl: RTL and testbench

//  Drives the 32-bit combinational ALU (a_in/b_in/f_in -> y_out/zero/c_out) on the MIPS datapath.

---
 rtl/alu_issue_ctrl_if.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/ALU/response signal bundle between decode, alu_issue_ctrl and the combinational ALU.
// The slave modport is the controller's view; master is the environment's view.
interface alu_issue_if #(parameter int WIDTH = 32);
  logic             req_valid_in;
  logic             req_ready_out;
  logic [5:0]       op_in;
  logic [5:0]       funct_in;
  logic [4:0]       shamt_in;
  logic [WIDTH-1:0] rs_val_in;
  logic [WIDTH-1:0] rt_val_in;
  logic [15:0]      imm_in;
  logic [WIDTH-1:0] alu_a_out;
  logic [WIDTH-1:0] alu_b_out;
  logic [2:0]       alu_f_out;
  logic [WIDTH-1:0] alu_y_in;
  logic             alu_zero_in;
  logic             alu_cout_in;
  logic             rsp_valid_out;
  logic             rsp_ready_in;
  logic [WIDTH-1:0] result_out;
  logic             carry_out;
  logic             branch_taken_out;
  logic             illegal_out;

  modport slave (
    input  req_valid_in, op_in, funct_in, shamt_in, rs_val_in, rt_val_in, imm_in,
    input  alu_y_in, alu_zero_in, alu_cout_in, rsp_ready_in,
    output req_ready_out, alu_a_out, alu_b_out, alu_f_out,
    output rsp_valid_out, result_out, carry_out, branch_taken_out, illegal_out
  );

  modport master (
    output req_valid_in, op_in, funct_in, shamt_in, rs_val_in, rt_val_in, imm_in,
    output alu_y_in, alu_zero_in, alu_cout_in, rsp_ready_in,
    input  req_ready_out, alu_a_out, alu_b_out, alu_f_out,
    input  rsp_valid_out, result_out, carry_out, branch_taken_out, illegal_out
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational MIPS ALU: decodes opcode/funct into an f code,
// runs one ALU cycle (or shamt self-add cycles for SLL) and holds the response until taken.
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  function automatic logic [WIDTH-1:0] sign_ext(input logic [15:0] imm);
    return {{(WIDTH-16){imm[15]}}, imm};
  endfunction

  function automatic logic [WIDTH-1:0] zero_ext(input logic [15:0] imm);
    return {{(WIDTH-16){1'b0}}, imm};
  endfunction

  state_t           state_q, state_nx;
  logic             accept;
  logic             dec_legal, dec_sll;
  logic [2:0]       dec_f;
  logic [WIDTH-1:0] dec_b;
  br_t              dec_br;

  logic [WIDTH-1:0] a_p0, b_p0, acc_p0;
  logic [2:0]       f_p0;
  br_t              br_p0;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, branch_q, illegal_q;

  assign accept = (state_q == IDLE) && bus.req_valid_in;

  always_comb begin
    dec_legal = 1'b1;
    dec_sll   = 1'b0;
    dec_f     = F_ADD;
    dec_b     = bus.rt_val_in;
    dec_br    = BR_NONE;
    unique case (bus.op_in)
      6'h00: begin
        unique case (bus.funct_in)
          6'h20, 6'h21: dec_f = F_ADD;
          6'h22, 6'h23: dec_f = F_SUB;
          6'h24:        dec_f = F_AND;
          6'h25:        dec_f = F_OR;
          6'h2A:        dec_f = F_SLT;
          6'h00:        dec_sll = 1'b1;
          default:      dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: dec_b = sign_ext(bus.imm_in);
      6'h0A: begin dec_f = F_SLT; dec_b = sign_ext(bus.imm_in); end
      6'h0C: begin dec_f = F_AND; dec_b = zero_ext(bus.imm_in); end
      6'h0D: begin dec_f = F_OR;  dec_b = zero_ext(bus.imm_in); end
      6'h04: begin dec_f = F_SUB; dec_br = BR_EQ; end
      6'h05: begin dec_f = F_SUB; dec_br = BR_NE; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid_in) begin
        if (!dec_legal)                    state_nx = RESP;
        else if (dec_sll && bus.shamt_in == 5'd0) state_nx = RESP;
        else if (dec_sll)                  state_nx = SHIFT;
        else                               state_nx = EXEC;
      end
      EXEC:  state_nx = RESP;
      SHIFT: if (cnt_q == 5'd1) state_nx = RESP;
      RESP:  if (bus.rsp_ready_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // p0: operands latched at accept; the shift accumulator follows the ALU sum
  always_ff @(posedge clk_in) begin
    if (accept) begin
      a_p0   <= bus.rs_val_in;
      b_p0   <= dec_b;
      f_p0   <= dec_f;
      br_p0  <= dec_br;
      acc_p0 <= bus.rt_val_in;
    end else if (state_q == SHIFT) begin
      acc_p0 <= bus.alu_y_in;
    end
  end

  // Response capture: all of it is visible state, so it is cleared by reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid_in) begin
          cnt_q     <= bus.shamt_in;
          result_q  <= dec_legal ? bus.rt_val_in : '0;
          carry_q   <= 1'b0;
          branch_q  <= 1'b0;
          illegal_q <= !dec_legal;
        end
        EXEC: begin
          result_q <= bus.alu_y_in;
          carry_q  <= bus.alu_cout_in;
          branch_q <= ((br_p0 == BR_EQ) &&  bus.alu_zero_in) ||
                      ((br_p0 == BR_NE) && !bus.alu_zero_in);
        end
        SHIFT: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_q <= bus.alu_y_in;
            carry_q  <= bus.alu_cout_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.alu_a_out = '0;
    bus.alu_b_out = '0;
    bus.alu_f_out = F_AND;
    unique case (state_q)
      EXEC: begin
        bus.alu_a_out = a_p0;
        bus.alu_b_out = b_p0;
        bus.alu_f_out = f_p0;
      end
      SHIFT: begin
        bus.alu_a_out = acc_p0;
        bus.alu_b_out = acc_p0;
        bus.alu_f_out = F_ADD;
      end
      default: ;
    endcase
  end

  assign bus.req_ready_out    = (state_q == IDLE);
  assign bus.rsp_valid_out    = (state_q == RESP);
  assign bus.result_out       = result_q;
  assign bus.carry_out        = carry_q;
  assign bus.branch_taken_out = branch_q;
  assign bus.illegal_out      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU drives the ALU return path,
// a reference model predicts each response, and a monitor checks them as they appear.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pending_hold = 0;

  alu_issue_if #(.WIDTH(32)) bus ();

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Behavioural 32-bit ALU: adder with optional b inversion, c_out from the adder.
  logic [32:0] alu_sum;
  logic [31:0] alu_bb;
  always_comb begin
    alu_bb  = bus.alu_f_out[2] ? ~bus.alu_b_out : bus.alu_b_out;
    alu_sum = {1'b0, bus.alu_a_out} + {1'b0, alu_bb} + {32'd0, bus.alu_f_out[2]};
    bus.alu_y_in    = 32'd0;
    bus.alu_cout_in = 1'b0;
    case (bus.alu_f_out[1:0])
      2'b00: bus.alu_y_in = bus.alu_a_out & bus.alu_b_out;
      2'b01: bus.alu_y_in = bus.alu_a_out | bus.alu_b_out;
      2'b10: begin bus.alu_y_in = alu_sum[31:0]; bus.alu_cout_in = alu_sum[32]; end
      default: begin
        bus.alu_y_in    = {31'd0, $signed(bus.alu_a_out) < $signed(bus.alu_b_out)};
        bus.alu_cout_in = alu_sum[32];
      end
    endcase
    bus.alu_zero_in = (bus.alu_y_in == 32'd0);
  end

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        branch;
    logic        illegal;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference model: what each instruction means, plus what the ALU port shows one cycle after accept.
  function automatic void model(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] sh,
                                input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                                output exp_t e, output logic [2:0] f1, output logic [31:0] a1,
                                output logic [31:0] b1);
    logic [31:0] sx, zx, y, tmp;
    logic [32:0] wide;
    int kind;
    sx = {{16{imm[15]}}, imm};
    zx = {16'd0, imm};
    y = rt;
    kind = -1;
    e.result = 0; e.carry = 0; e.branch = 0; e.illegal = 0; e.lat = 1; e.acc_cyc = 0; e.name = "";
    f1 = 3'b000; a1 = 0; b1 = 0;
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h21: kind = 0;
        6'h22, 6'h23: kind = 1;
        6'h24: kind = 2;
        6'h25: kind = 3;
        6'h2A: kind = 4;
        6'h00: kind = 5;
        default: kind = -1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: begin kind = 0; y = sx; end
        6'h0A: begin kind = 4; y = sx; end
        6'h0C: begin kind = 2; y = zx; end
        6'h0D: begin kind = 3; y = zx; end
        6'h04: begin kind = 1; e.branch = (rs == rt); end
        6'h05: begin kind = 1; e.branch = (rs != rt); end
        default: kind = -1;
      endcase
    end
    a1 = rs; b1 = y;
    case (kind)
      0: begin wide = {1'b0, rs} + {1'b0, y}; e.result = wide[31:0]; e.carry = wide[32]; f1 = 3'b010; end
      1: begin e.result = rs - y; e.carry = (rs >= y); f1 = 3'b110; end
      2: begin e.result = rs & y; f1 = 3'b000; end
      3: begin e.result = rs | y; f1 = 3'b001; end
      4: begin e.result = {31'd0, $signed(rs) < $signed(y)}; e.carry = (rs >= y); f1 = 3'b111; end
      5: begin
        if (sh == 0) begin
          e.result = rt; e.lat = 0; a1 = 0; b1 = 0;
        end else begin
          e.result = rt << sh;
          tmp = rt << (sh - 1);
          e.carry = tmp[31];
          e.lat = int'(sh);
          f1 = 3'b010; a1 = rt; b1 = rt;
        end
      end
      default: begin e.illegal = 1; e.lat = 0; a1 = 0; b1 = 0; end
    endcase
  endfunction

  task automatic issue(input string name, input logic [5:0] op, input logic [5:0] funct,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm);
    exp_t e;
    logic [2:0] f1;
    logic [31:0] a1, b1;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready_out && w < 400) begin @(negedge clk); w++; end
    if (!bus.req_ready_out) begin
      chk({name, "_ready_timeout"}, {31'd0, bus.req_ready_out}, 32'd1);
      return;
    end
    model(op, funct, sh, rs, rt, imm, e, f1, a1, b1);
    e.name = name;
    bus.op_in = op; bus.funct_in = funct; bus.shamt_in = sh;
    bus.rs_val_in = rs; bus.rt_val_in = rt; bus.imm_in = imm;
    bus.req_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_in = 1'b0;
    e.acc_cyc = cyc;
    sb.push_back(e);
    chk({name, "_alu_f"}, {29'd0, bus.alu_f_out}, {29'd0, f1});
    chk({name, "_alu_a"}, bus.alu_a_out, a1);
    chk({name, "_alu_b"}, bus.alu_b_out, b1);
    chk({name, "_req_ready"}, {31'd0, bus.req_ready_out}, 32'd0);
  endtask

  // Monitor: pops the scoreboard on each new response, then checks outputs stay put while held.
  initial begin
    exp_t e;
    bit   cur, have;
    int   hold;
    cur = 0; have = 0; hold = 0;
    bus.rsp_ready_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid_out) begin
        if (!cur) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", {31'd0, bus.rsp_valid_out}, 32'd0);
            have = 0;
          end else begin
            e = sb.pop_front();
            have = 1;
            chk({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
          end
          cur = 1;
          hold = pending_hold;
          pending_hold = 0;
        end
        if (have) begin
          chk({e.name, "_result"},  bus.result_out, e.result);
          chk({e.name, "_carry"},   {31'd0, bus.carry_out}, {31'd0, e.carry});
          chk({e.name, "_branch"},  {31'd0, bus.branch_taken_out}, {31'd0, e.branch});
          chk({e.name, "_illegal"}, {31'd0, bus.illegal_out}, {31'd0, e.illegal});
          chk({e.name, "_resp_alu_f"}, {29'd0, bus.alu_f_out}, 32'd0);
        end
        if (hold > 0) begin
          hold--;
          bus.rsp_ready_in = 1'b0;
        end else begin
          bus.rsp_ready_in = ($urandom_range(0, 3) != 0);
        end
        if (bus.rsp_ready_in) cur = 0;
      end else begin
        cur = 0;
        bus.rsp_ready_in = $urandom_range(0, 1) != 0;
      end
    end
  end

  logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A,
                              6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05};
  logic [5:0] fn_tab [9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00};

  initial begin
    logic [5:0] op, fn;
    logic [31:0] rs, rt;
    int w;
    bus.req_valid_in = 1'b0;
    bus.op_in = '0; bus.funct_in = '0; bus.shamt_in = '0;
    bus.rs_val_in = '0; bus.rt_val_in = '0; bus.imm_in = '0;
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready_out}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid_out}, 32'd0);
    chk("rst_result",    bus.result_out, 32'd0);
    chk("rst_flags",     {29'd0, bus.carry_out, bus.branch_taken_out, bus.illegal_out}, 32'd0);
    chk("rst_alu_f",     {29'd0, bus.alu_f_out}, 32'd0);
    chk("rst_alu_ab",    bus.alu_a_out | bus.alu_b_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add",      6'h00, 6'h20, 5'd0, 32'd7, 32'd5, 16'h0);
    issue("beq_eq",   6'h04, 6'h00, 5'd0, 32'h1234, 32'h1234, 16'h0);
    issue("bne_eq",   6'h05, 6'h00, 5'd0, 32'h1234, 32'h1234, 16'h0);
    issue("beq_ne",   6'h04, 6'h00, 5'd0, 32'd1, 32'd2, 16'h0);
    issue("bne_ne",   6'h05, 6'h00, 5'd0, 32'd1, 32'd2, 16'h0);
    issue("slt_neg",  6'h00, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0);
    issue("slti",     6'h0A, 6'h00, 5'd0, 32'd5, 32'd0, 16'hFFFF);
    issue("andi_zx",  6'h0C, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd0, 16'h8000);
    issue("sll4",     6'h00, 6'h00, 5'd4, 32'd0, 32'h0000_0003, 16'h0);
    issue("sll0",     6'h00, 6'h00, 5'd0, 32'd9, 32'hABCD_0123, 16'h0);
    issue("sll_cout", 6'h00, 6'h00, 5'd1, 32'd0, 32'h8000_0001, 16'h0);
    pending_hold = 5;
    issue("illegal",  6'h3F, 6'h00, 5'd0, 32'd3, 32'd4, 16'h0);

    issue("sll_abort", 6'h00, 6'h00, 5'd20, 32'd0, 32'd1, 16'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid_out}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, bus.req_ready_out}, 32'd1);
    chk("mid_rst_alu_f",     {29'd0, bus.alu_f_out}, 32'd0);
    chk("mid_rst_result",    bus.result_out, 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue("post_rst_add", 6'h00, 6'h21, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0);

    for (int i = 0; i < 150; i++) begin
      w  = $urandom_range(0, 12);
      op = (w == 12) ? 6'($urandom) : op_tab[w];
      w  = $urandom_range(0, 9);
      fn = (w == 9) ? 6'($urandom) : fn_tab[w];
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      issue($sformatf("rnd%0d", i), op, fn, 5'($urandom), rs, rt, 16'($urandom));
    end

    w = 0;
    while (sb.size() != 0 && w < 500) begin @(negedge clk); w++; end
    chk("drain_pending", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
